// File: rtl/axis_output_sink_pkg.sv
// Shared types and helpers for the AXI-Stream output sink: FSM encoding,
// lane-count derivation and lowest-set-bit search.
package axis_output_sink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sink_state_e;

  // Upper bound on lanes the lowest-set-bit search can handle.
  localparam int MAX_LANES = 32;

  function automatic int calc_lanes(input int s_width, input int w_width);
    return s_width / w_width;
  endfunction

  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int unsigned lowest_set(input logic [MAX_LANES-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/output_sink_lane_sel.sv
// Combinational priority select of the lowest set keep bit: returns its lane
// index, the word in that lane, the mask with that bit cleared and a last flag.
module output_sink_lane_sel
  import axis_output_sink_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int WORD_WIDTH = 32,
  parameter int IDX_W      = idx_width(LANES)
) (
  input  logic [LANES-1:0]            mask,
  input  logic [LANES*WORD_WIDTH-1:0] data,
  output logic [IDX_W-1:0]            lane_idx,
  output logic [WORD_WIDTH-1:0]       word,
  output logic [LANES-1:0]            mask_rem,
  output logic                        last
);

  logic [LANES-1:0] onehot;

  always_comb begin
    lane_idx = IDX_W'(lowest_set(MAX_LANES'(mask)));
    mask_rem = mask & (mask - LANES'(1));
    onehot   = mask & ~mask_rem;
    last     = (mask_rem == '0);
    word     = '0;
    for (int i = 0; i < LANES; i++) begin
      word = word | (data[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{onehot[i]}});
    end
  end

endmodule

// File: rtl/axis_output_sink.sv
// AXI-Stream sink that unpacks kept accumulator words into a word-addressed
// SRAM write port. Optional keep-contiguity check: OUTPUT_SINK_KEEP_CHECK_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start, tready low
// ST_RECV  | accepting a beat
// ST_DRAIN | writing one kept word per cycle, tready low
// ST_DONE  | one-cycle completion pulse
module axis_output_sink
  import axis_output_sink_pkg::*;
#(
  parameter int S_DATA_WIDTH = 128,
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int LANES        = calc_lanes(S_DATA_WIDTH, WORD_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [LANES-1:0]        s_axis_tkeep,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
  output logic [WORD_WIDTH-1:0]   mem_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     words_written,
  output logic                    keep_err
);

  localparam int IDX_W = idx_width(LANES);

  sink_state_e state, state_nxt;

  logic [ADDR_WIDTH-1:0]   addr_cnt;
  logic [S_DATA_WIDTH-1:0] data_r;
  logic [LANES-1:0]        rem_r;
  logic                    last_beat_r;
  logic                    last_wr_r;
  logic                    accept;
  logic                    arm;
  logic                    issue;

  logic [LANES-1:0]        sel_mask;
  logic [S_DATA_WIDTH-1:0] sel_data;
  logic [IDX_W-1:0]        sel_idx;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic [LANES-1:0]        sel_rem;
  logic                    sel_last;

  assign s_axis_tready = (state == ST_RECV);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign accept        = s_axis_tready && s_axis_tvalid;
  assign arm           = (state == ST_IDLE) && start;

  // In RECV the first word is issued straight from the bus so writes begin the cycle after the handshake.
  assign sel_mask = (state == ST_DRAIN) ? rem_r  : s_axis_tkeep;
  assign sel_data = (state == ST_DRAIN) ? data_r : s_axis_tdata;

  output_sink_lane_sel #(
    .LANES      (LANES),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_W      (IDX_W)
  ) u_lane_sel (
    .mask     (sel_mask),
    .data     (sel_data),
    .lane_idx (sel_idx),
    .word     (sel_word),
    .mask_rem (sel_rem),
    .last     (sel_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (accept) begin
          if (s_axis_tkeep != '0) begin
            issue     = 1'b1;
            state_nxt = ST_DRAIN;
          end else if (s_axis_tlast) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (last_wr_r) state_nxt = last_beat_r ? ST_DONE : ST_RECV;
        else           issue     = 1'b1;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt      <= '0;
      data_r        <= '0;
      rem_r         <= '0;
      last_beat_r   <= 1'b0;
      last_wr_r     <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_wr_addr   <= '0;
      mem_wr_data   <= '0;
      words_written <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      if (arm) begin
        addr_cnt      <= base_addr;
        words_written <= '0;
      end
      if (accept) begin
        data_r      <= s_axis_tdata;
        last_beat_r <= s_axis_tlast;
      end
      if (issue) begin
        mem_wr_en   <= 1'b1;
        mem_wr_addr <= addr_cnt;
        mem_wr_data <= sel_word;
        addr_cnt    <= addr_cnt + ADDR_WIDTH'(1);
        rem_r       <= sel_rem;
        last_wr_r   <= sel_last;
        if (words_written != '1) words_written <= words_written + (ADDR_WIDTH+1)'(1);
      end
    end
  end

`ifdef OUTPUT_SINK_KEEP_CHECK_EN
  logic keep_err_r;

  // A set bit above a clear one means keep is not a run of ones from lane 0.
  always_ff @(posedge clk) begin
    if (rst)
      keep_err_r <= 1'b0;
    else if (arm)
      keep_err_r <= 1'b0;
    else if (accept && ((s_axis_tkeep & (s_axis_tkeep + LANES'(1))) != '0))
      keep_err_r <= 1'b1;
  end

  assign keep_err = keep_err_r;
`else
  assign keep_err = 1'b0;
`endif

endmodule
